// File: rtl/addsub_pkg.sv
// Shared encodings for the add/subtract accumulator: opcodes, run state and
// the 7-segment glyphs used by the error display.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic {
    RUN   = 1'b0,
    ERROR = 1'b1
  } state_e;

  // Active-low gfedcba patterns
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic valid;
    logic ov;
  } res_t;

endpackage

// File: rtl/addsub_acc_seg7_hex.sv
// Hex nibble to active-low gfedcba 7-segment pattern.
module seg7_hex (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/addsub_acc.sv
// Signed add/sub accumulator with overflow detection, optional saturation,
// sticky ERROR state and a blinking "Er" on the hex digits.
module addsub_acc
  import addsub_pkg::*;
#(
  parameter int W         = 8,
  parameter int SATURATE  = 0,
  parameter int BLINK_CYC = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [W-1:0]       operand,
  input  logic               err_clr,
  output logic [W-1:0]       acc,
  output logic               res_valid,
  output logic               res_ov,
  output logic               ov_sticky,
  output logic               err,
  output logic               err_led,
  output logic [7*W/4-1:0]   seg
);

  localparam int ND = W / 4;
  localparam int CW = $clog2(BLINK_CYC);

  state_e         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  res_t           res_q, res_d;
  logic           stk_q, stk_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           phase_q, phase_d;

  // Subtraction reuses the adder: acc + ~operand + 1
  logic           is_sub;
  logic [W-1:0]   b_eff, sum, sat_val;
  logic           ov;

  assign is_sub  = (op_e'(op) == OP_SUB);
  assign b_eff   = is_sub ? ~operand : operand;
  assign sum     = acc_q + b_eff + {{(W-1){1'b0}}, is_sub};
  assign ov      = (acc_q[W-1] == b_eff[W-1]) && (sum[W-1] != acc_q[W-1]);
  // On overflow both addends share acc's sign, so acc's sign picks the rail
  assign sat_val = acc_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    res_d   = '0;
    stk_d   = stk_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    case (state_q)
      RUN: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (in_valid) begin
          res_d.valid = 1'b1;
          case (op_e'(op))
            OP_ADD, OP_SUB: begin
              if (ov) begin
                res_d.ov = 1'b1;
                stk_d    = 1'b1;
                if (SATURATE != 0) begin
                  acc_d = sat_val;
                end else begin
                  state_d = ERROR;
                  phase_d = 1'b1;
                end
              end else begin
                acc_d = sum;
              end
            end
            OP_LOAD: acc_d = operand;
            default: begin
              acc_d = '0;
              stk_d = 1'b0;
            end
          endcase
        end
      end
      default: begin
        if (err_clr) begin
          state_d = RUN;
          cnt_d   = '0;
          phase_d = 1'b0;
        end else if (cnt_q == CW'(BLINK_CYC - 1)) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      acc_q   <= '0;
      res_q   <= '0;
      stk_q   <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      stk_q   <= stk_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign in_ready  = (state_q == RUN);
  assign acc       = acc_q;
  assign res_valid = res_q.valid;
  assign res_ov    = res_q.ov;
  assign ov_sticky = stk_q;
  assign err       = (state_q == ERROR);
  assign err_led   = (state_q == ERROR) && phase_q;

  logic [ND-1:0][6:0] hex_seg, seg_d;

  for (genvar i = 0; i < ND; i++) begin : g_dig
    seg7_hex u_hex (
      .nib (acc_q[4*i +: 4]),
      .seg (hex_seg[i])
    );
  end

  always_comb begin
    seg_d = hex_seg;
    if (state_q == ERROR) begin
      for (int i = 0; i < ND; i++) seg_d[i] = SEG_BLANK;
      if (phase_q) begin
        seg_d[ND-1] = SEG_E;
        seg_d[ND-2] = SEG_R;
      end
    end
  end

  assign seg = seg_d;

endmodule

// File: tb/tb_addsub_acc.sv
// Three accumulators (W8 error mode, W8 saturating, W16 error mode) share one
// stimulus stream and are each tracked by a plain-integer reference model.
module tb_addsub_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, err_clr;
  logic [1:0]  op;
  logic [15:0] operand;

  logic [7:0]  a_acc, b_acc;
  logic [15:0] c_acc;
  logic [13:0] a_seg, b_seg;
  logic [27:0] c_seg;
  logic a_rdy, a_rv, a_rov, a_stk, a_err, a_led;
  logic b_rdy, b_rv, b_rov, b_stk, b_err, b_led;
  logic c_rdy, c_rv, c_rov, c_stk, c_err, c_led;

  addsub_acc #(.W(8), .SATURATE(0), .BLINK_CYC(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_rdy), .op(op),
    .operand(operand[7:0]), .err_clr(err_clr), .acc(a_acc), .res_valid(a_rv),
    .res_ov(a_rov), .ov_sticky(a_stk), .err(a_err), .err_led(a_led), .seg(a_seg));

  addsub_acc #(.W(8), .SATURATE(1), .BLINK_CYC(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_rdy), .op(op),
    .operand(operand[7:0]), .err_clr(err_clr), .acc(b_acc), .res_valid(b_rv),
    .res_ov(b_rov), .ov_sticky(b_stk), .err(b_err), .err_led(b_led), .seg(b_seg));

  addsub_acc #(.W(16), .SATURATE(0), .BLINK_CYC(3)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_rdy), .op(op),
    .operand(operand), .err_clr(err_clr), .acc(c_acc), .res_valid(c_rv),
    .res_ov(c_rov), .ov_sticky(c_stk), .err(c_err), .err_led(c_led), .seg(c_seg));

  logic [15:0] d_acc [3];
  logic [27:0] d_seg [3];
  logic d_rdy [3], d_rv [3], d_rov [3], d_stk [3], d_err [3], d_led [3];

  assign d_acc[0] = {8'h00, a_acc};  assign d_seg[0] = {14'h0, a_seg};
  assign d_acc[1] = {8'h00, b_acc};  assign d_seg[1] = {14'h0, b_seg};
  assign d_acc[2] = c_acc;           assign d_seg[2] = c_seg;
  assign d_rdy[0] = a_rdy; assign d_rv[0] = a_rv; assign d_rov[0] = a_rov;
  assign d_stk[0] = a_stk; assign d_err[0] = a_err; assign d_led[0] = a_led;
  assign d_rdy[1] = b_rdy; assign d_rv[1] = b_rv; assign d_rov[1] = b_rov;
  assign d_stk[1] = b_stk; assign d_err[1] = b_err; assign d_led[1] = b_led;
  assign d_rdy[2] = c_rdy; assign d_rv[2] = c_rv; assign d_rov[2] = c_rov;
  assign d_stk[2] = c_stk; assign d_err[2] = c_err; assign d_led[2] = c_led;

  // Reference model: accumulator held as a true signed integer
  int     mw   [3] = '{8, 8, 16};
  int     msat [3] = '{0, 1, 0};
  int     mbl  [3] = '{4, 4, 3};
  longint macc [3];
  bit     merr [3], mph [3], mrv [3], mrov [3], mstk [3];
  int     mcnt [3];

  logic [6:0] hex7 [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int vectors = 0;
  int miscompares = 0;

  function automatic longint sx(logic [15:0] v, int w);
    if (w == 8) return longint'($signed(v[7:0]));
    return longint'($signed(v));
  endfunction

  function automatic logic [15:0] acc_bits(int i);
    logic [63:0] v;
    v = macc[i];
    if (mw[i] == 8) return {8'h00, v[7:0]};
    return v[15:0];
  endfunction

  function automatic logic [27:0] exp_seg(int i);
    logic [27:0] s;
    logic [15:0] a;
    int nd;
    s  = '0;
    a  = acc_bits(i);
    nd = mw[i] / 4;
    for (int d = 0; d < nd; d++) begin
      if (!merr[i])                   s[7*d +: 7] = hex7[(a >> (4*d)) & 16'hF];
      else if (mph[i] && d == nd - 1) s[7*d +: 7] = 7'b0000110;
      else if (mph[i] && d == nd - 2) s[7*d +: 7] = 7'b0101111;
      else                            s[7*d +: 7] = 7'b1111111;
    end
    return s;
  endfunction

  task automatic model_reset(int i);
    macc[i] = 0; merr[i] = 0; mph[i] = 0; mrv[i] = 0; mrov[i] = 0;
    mstk[i] = 0; mcnt[i] = 0;
  endtask

  task automatic model_step(int i);
    longint a, b, t, mx, mn;
    mrv[i] = 0; mrov[i] = 0;
    if (!rst_n) begin
      model_reset(i);
    end else if (!merr[i]) begin
      if (in_valid) begin
        mrv[i] = 1;
        a  = macc[i];
        b  = sx(operand, mw[i]);
        mx = (longint'(1) << (mw[i] - 1)) - 1;
        mn = -(longint'(1) << (mw[i] - 1));
        if (op == 2'd2) macc[i] = b;
        else if (op == 2'd3) begin macc[i] = 0; mstk[i] = 0; end
        else begin
          t = (op == 2'd0) ? a + b : a - b;
          if (t > mx || t < mn) begin
            mrov[i] = 1; mstk[i] = 1;
            if (msat[i] != 0) macc[i] = (t > 0) ? mx : mn;
            else begin merr[i] = 1; mcnt[i] = 0; mph[i] = 1; end
          end else macc[i] = t;
        end
      end
    end else if (err_clr) begin
      merr[i] = 0; mcnt[i] = 0; mph[i] = 0;
    end else if (mcnt[i] == mbl[i] - 1) begin
      mcnt[i] = 0; mph[i] = !mph[i];
    end else mcnt[i]++;
  endtask

  task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, i, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("acc", i, 32'(d_acc[i]), 32'(acc_bits(i)));
      chk("seg", i, 32'(d_seg[i]), 32'(exp_seg(i)));
      chk("in_ready", i, 32'(d_rdy[i]), 32'(!merr[i]));
      chk("res_valid", i, 32'(d_rv[i]), 32'(mrv[i]));
      if (mrv[i]) chk("res_ov", i, 32'(d_rov[i]), 32'(mrov[i]));
      chk("ov_sticky", i, 32'(d_stk[i]), 32'(mstk[i]));
      chk("err", i, 32'(d_err[i]), 32'(merr[i]));
      chk("err_led", i, 32'(d_led[i]), 32'(merr[i] && mph[i]));
    end
  endtask

  // One clock: inputs already stable since the falling edge
  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    check_all();
  endtask

  task automatic op_cyc(bit v, logic [1:0] o, logic [15:0] d, bit c);
    in_valid = v; op = o; operand = d; err_clr = c;
    cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) model_reset(i);
    check_all();
    cycle();
    rst_n = 1'b1;
  endtask

  logic [15:0] edge_vals [8] = '{16'h0000, 16'h0001, 16'h007F, 16'h0080,
                                 16'h00FF, 16'h7FFF, 16'h8000, 16'hFFFF};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; err_clr = 1'b0; op = 2'd0; operand = '0;
    for (int i = 0; i < 3; i++) model_reset(i);
    cycle();
    cycle();
    chk("rst_seg_00", 0, 32'(a_seg), 32'({7'b1000000, 7'b1000000}));
    rst_n = 1'b1;

    // Saturation boundary / ERROR entry
    op_cyc(1, 2'd2, 16'h0070, 0);
    op_cyc(1, 2'd0, 16'h000F, 0);
    chk("pin_acc_7f", 0, 32'(a_acc), 32'h7F);
    chk("pin_model_7f", 0, 32'(acc_bits(0)), 32'h7F);
    chk("pin_seg_7f", 0, 32'(a_seg), 32'({7'b1111000, 7'b0001110}));
    op_cyc(1, 2'd0, 16'h0001, 0);
    chk("pin_ov_hold", 0, 32'({a_acc, a_rov, a_err, a_rdy}), 32'({8'h7F, 3'b110}));
    chk("pin_seg_er", 0, 32'(a_seg), 32'({7'b0000110, 7'b0101111}));
    chk("pin_b_sat", 1, 32'({b_acc, b_rov, b_err}), 32'({8'h7F, 2'b10}));
    op_cyc(1, 2'd0, 16'h0001, 0);
    chk("pin_err_ignore", 0, 32'({a_acc, a_rv}), 32'({8'h7F, 1'b0}));
    repeat (3) op_cyc(0, 2'd0, 16'h0000, 0);
    chk("pin_blank", 0, 32'(a_seg), 32'h3FFF);
    op_cyc(0, 2'd0, 16'h0000, 1);
    chk("pin_clr_run", 0, 32'({a_err, a_rdy, a_stk}), 32'b011);
    op_cyc(1, 2'd3, 16'h0000, 0);
    chk("pin_clear", 0, 32'({a_acc, a_stk}), 32'({8'h00, 1'b0}));

    // Saturating corners
    op_cyc(1, 2'd2, 16'h0080, 0);
    op_cyc(1, 2'd1, 16'h0001, 0);
    chk("pin_b_min", 1, 32'({b_acc, b_rov, b_err}), 32'({8'h80, 2'b10}));
    op_cyc(0, 2'd0, 16'h0000, 1);
    op_cyc(1, 2'd2, 16'h0000, 0);
    op_cyc(1, 2'd1, 16'h0080, 0);
    chk("pin_b_max", 1, 32'({b_acc, b_rov}), 32'({8'h7F, 1'b1}));
    chk("pin_model_max", 1, 32'(acc_bits(1)), 32'h7F);
    op_cyc(0, 2'd0, 16'h0000, 1);

    // Back-to-back accepts on the wide instance
    op_cyc(1, 2'd3, 16'h0000, 0);
    op_cyc(1, 2'd0, 16'h1234, 0);
    chk("pin_c_rv1", 2, 32'(c_rv), 32'h1);
    op_cyc(1, 2'd1, 16'h0234, 0);
    chk("pin_c_rv2", 2, 32'(c_rv), 32'h1);
    chk("pin_c_acc", 2, 32'(c_acc), 32'h1000);
    chk("pin_c_seg", 2, 32'(c_seg),
        32'({7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000}));

    // Reset mid-blink
    op_cyc(1, 2'd2, 16'h007F, 0);
    op_cyc(1, 2'd0, 16'h0001, 0);
    op_cyc(0, 2'd0, 16'h0000, 0);
    op_cyc(0, 2'd0, 16'h0000, 0);
    do_reset();
    chk("pin_rst_seg", 0, 32'(a_seg), 32'({7'b1000000, 7'b1000000}));
    chk("pin_rst_rdy", 0, 32'({a_rdy, a_err, a_led}), 32'b100);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] d;
      d = ($urandom_range(3) == 0) ? edge_vals[$urandom_range(7)] : 16'($urandom);
      if ($urandom_range(199) == 0) do_reset();
      else op_cyc($urandom_range(9) < 7, 2'($urandom_range(3)), d,
                  $urandom_range(9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
